// File: rtl/plab2_mem_dmem_sec_guard_if.sv
// Valid/ready channel bundle used by the request and response ports
// of the data-memory security guard.
interface plab2_mem_dmem_sec_guard_if #(
   parameter int W = 77
) ();
   logic [W-1:0] msg;
   logic         val;
   logic         rdy;

   modport master (output msg, output val, input rdy);
   modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/plab2_mem_dmem_sec_guard.sv
// Data-memory secure-window guard; optional violation counter enabled
// by defining PLAB2_DMEM_SEC_GUARD_VIOL_CNT_EN.
module plab2_mem_dmem_sec_guard #(
   parameter logic [31:0] p_sec_base        = 32'h0000_8000,
   parameter logic [31:0] p_sec_limit       = 32'h0000_FFFF,
   parameter int unsigned p_max_outstanding = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_domain,
   plab2_mem_dmem_sec_guard_if.slave   in_req,
   plab2_mem_dmem_sec_guard_if.master  out_req,
   plab2_mem_dmem_sec_guard_if.slave   mem_resp,
   plab2_mem_dmem_sec_guard_if.master  out_resp,
   output logic                        viol_intr,
   output logic [31:0]                 viol_addr,
   input  logic                        viol_clr
`ifdef PLAB2_DMEM_SEC_GUARD_VIOL_CNT_EN
   ,
   output logic [7:0]                  viol_cnt
`endif
);

   localparam int AW = (p_max_outstanding > 1) ?
                       $clog2(p_max_outstanding) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] MAXO = CW'(p_max_outstanding);

   typedef struct packed {
      logic       synth;
      logic [2:0] typ;
      logic [7:0] opq;
   } tag_t;

   logic          pipe_val_q, pipe_val_d;
   logic [76:0]   pipe_msg_q, pipe_msg_d;
   logic          pipe_viol_q, pipe_viol_d;
   tag_t          tag_q [p_max_outstanding];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          viol_intr_q, viol_intr_d;
   logic [31:0]   viol_addr_q, viol_addr_d;

   logic [31:0]   in_addr;
   logic          in_viol;
   logic          tag_ok;
   logic          pipe_leave;
   logic          accept;
   logic          pop;
   logic          viol_ev;
   tag_t          head;

   assign in_addr    = in_req.msg[65:34];
   assign in_viol    = !req_domain &&
                       (in_addr >= p_sec_base) &&
                       (in_addr <= p_sec_limit);
   assign tag_ok     = cnt_q < MAXO;
   assign pipe_leave = pipe_val_q && tag_ok &&
                       (pipe_viol_q || out_req.rdy);
   // Ready is forced low while reset is held
   assign in_req.rdy = reset && (!pipe_val_q || pipe_leave);
   assign accept     = in_req.val && in_req.rdy;
   assign viol_ev    = pipe_leave && pipe_viol_q;

   assign out_req.val = pipe_val_q && !pipe_viol_q && tag_ok;
   assign out_req.msg = pipe_msg_q;

   assign head = tag_q[rd_ptr_q];
   assign pop  = out_resp.val && out_resp.rdy;

   always_comb begin
      out_resp.val = 1'b0;
      out_resp.msg = mem_resp.msg;
      mem_resp.rdy = 1'b0;
      if (cnt_q != '0) begin
         if (head.synth) begin
            out_resp.val = 1'b1;
            out_resp.msg = {head.typ, head.opq, 2'd0, 32'h0};
         end else begin
            out_resp.val = mem_resp.val;
            mem_resp.rdy = out_resp.rdy;
         end
      end
   end

   always_comb begin
      pipe_val_d  = pipe_val_q;
      pipe_msg_d  = pipe_msg_q;
      pipe_viol_d = pipe_viol_q;
      if (accept) begin
         pipe_val_d  = 1'b1;
         pipe_msg_d  = in_req.msg;
         pipe_viol_d = in_viol;
      end else if (pipe_leave) begin
         pipe_val_d  = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(pipe_leave);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + CW'(pipe_leave) - CW'(pop);
   end

   // A clear in the same cycle as a new violation drops that violation
   always_comb begin
      viol_intr_d = viol_intr_q;
      viol_addr_d = viol_addr_q;
      if (viol_clr) begin
         viol_intr_d = 1'b0;
         viol_addr_d = 32'h0;
      end else if (viol_ev) begin
         viol_intr_d = 1'b1;
         if (!viol_intr_q)
            viol_addr_d = pipe_msg_q[65:34];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_val_q  <= 1'b0;
         pipe_msg_q  <= '0;
         pipe_viol_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         viol_intr_q <= 1'b0;
         viol_addr_q <= 32'h0;
      end else begin
         pipe_val_q  <= pipe_val_d;
         pipe_msg_q  <= pipe_msg_d;
         pipe_viol_q <= pipe_viol_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         viol_intr_q <= viol_intr_d;
         viol_addr_q <= viol_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pipe_leave)
         tag_q[wr_ptr_q] <= '{synth: pipe_viol_q,
                              typ:   pipe_msg_q[76:74],
                              opq:   pipe_msg_q[73:66]};
   end

   assign viol_intr = viol_intr_q;
   assign viol_addr = viol_addr_q;

`ifdef PLAB2_DMEM_SEC_GUARD_VIOL_CNT_EN
   logic [7:0] viol_cnt_q, viol_cnt_d;

   always_comb begin
      viol_cnt_d = viol_cnt_q;
      if (viol_clr)
         viol_cnt_d = 8'h00;
      else if (viol_ev && viol_cnt_q != 8'hFF)
         viol_cnt_d = viol_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         viol_cnt_q <= 8'h00;
      else
         viol_cnt_q <= viol_cnt_d;
   end

   assign viol_cnt = viol_cnt_q;
`endif

endmodule

// File: tb/tb_plab2_mem_dmem_sec_guard.sv
// Randomized scoreboard bench for the data-memory secure-window guard.
// Directed boundary, ordering, stall, clear and reset scenarios included.
module tb_plab2_mem_dmem_sec_guard;

   localparam logic [31:0] SB = 32'h0000_8000;
   localparam logic [31:0] SL = 32'h0000_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_domain;
   logic        viol_clr;
   logic        viol_intr;
   logic [31:0] viol_addr;
`ifdef PLAB2_DMEM_SEC_GUARD_VIOL_CNT_EN
   logic [7:0]  viol_cnt;
`endif

   plab2_mem_dmem_sec_guard_if #(.W(77)) in_req ();
   plab2_mem_dmem_sec_guard_if #(.W(77)) out_req ();
   plab2_mem_dmem_sec_guard_if #(.W(45)) mem_resp ();
   plab2_mem_dmem_sec_guard_if #(.W(45)) out_resp ();

   always #5 clk = ~clk;

   plab2_mem_dmem_sec_guard dut (
      .clk        (clk),
      .reset      (reset),
      .req_domain (req_domain),
      .in_req     (in_req),
      .out_req    (out_req),
      .mem_resp   (mem_resp),
      .out_resp   (out_resp),
      .viol_intr  (viol_intr),
      .viol_addr  (viol_addr),
      .viol_clr   (viol_clr)
`ifdef PLAB2_DMEM_SEC_GUARD_VIOL_CNT_EN
      ,
      .viol_cnt   (viol_cnt)
`endif
   );

   typedef struct {
      logic [44:0] msg;
      int          due;
   } mrsp_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [44:0] exp_q [$];
   logic [76:0] fwd_q [$];
   mrsp_t       mem_q [$];
   int          cyc = 0;
   int          mem_lo = 0;
   int          mem_hi = 3;
   int          n_issue = 0;
   bit          f_in, f_out, f_mem, f_resp;
   bit          mv_set = 1'b0;
   logic [31:0] mv_addr = 32'h0;
   int          mv_n = 0;
   int          nsent;
   logic [31:0] bnd [4] = '{32'h7FFF, 32'h8000, 32'hFFFF, 32'h10000};

   task automatic check(input string tag, input logic [76:0] act,
                        input logic [76:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a,
                                            input logic [7:0] o);
      return {a[15:0], 16'hCAFE} ^ {24'h0, o};
   endfunction

   function automatic logic [44:0] resp_of(input logic [76:0] m,
                                           input bit v);
      logic [31:0] a;
      a = m[65:34];
      return {m[76:74], m[73:66], 2'd0,
              v ? 32'h0 : mem_data(a, m[73:66])};
   endfunction

   task automatic cycle();
      logic [76:0] m;
      logic [31:0] a;
      bit          v;
      @(negedge clk);
      f_in   = in_req.val && in_req.rdy;
      f_out  = out_req.val && out_req.rdy;
      f_mem  = mem_resp.val && mem_resp.rdy;
      f_resp = out_resp.val && out_resp.rdy;
      if (f_in) begin
         a = in_req.msg[65:34];
         v = !req_domain && a >= SB && a <= SL;
         exp_q.push_back(resp_of(in_req.msg, v));
         if (!v) fwd_q.push_back(in_req.msg);
         else begin
            mv_n++;
            if (!mv_set) begin
               mv_set  = 1'b1;
               mv_addr = a;
            end
         end
      end
      if (f_out) begin
         n_issue++;
         check("oreq_pending", 77'(fwd_q.size() > 0), 77'(1));
         if (fwd_q.size() > 0) begin
            m = fwd_q.pop_front();
            check("oreq_msg", out_req.msg, m);
            mem_q.push_back('{msg: resp_of(m, 1'b0),
                              due: cyc + int'($urandom_range(mem_hi, mem_lo))});
         end
      end
      if (f_resp) begin
         check("resp_pending", 77'(exp_q.size() > 0), 77'(1));
         if (exp_q.size() > 0)
            check("resp_msg", 77'(out_resp.msg), 77'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
      cyc++;
      if (f_mem && mem_q.size() > 0) void'(mem_q.pop_front());
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         mem_resp.val = 1'b1;
         mem_resp.msg = mem_q[0].msg;
      end else begin
         mem_resp.val = 1'b0;
         mem_resp.msg = '0;
      end
      #1;
   endtask

   task automatic send(input bit dom, input logic [2:0] ty,
                       input logic [7:0] op, input logic [31:0] a);
      int t;
      t = 0;
      req_domain   = dom;
      in_req.msg   = {ty, op, a, 2'd0, 32'h1234_0000 ^ a};
      in_req.val   = 1'b1;
      do begin
         cycle();
         t++;
      end while (!f_in && t < 100);
      check("send_acc", 77'(f_in), 77'(1));
      in_req.val = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      in_req.val   = 1'b0;
      out_req.rdy  = 1'b1;
      out_resp.rdy = 1'b1;
      while ((exp_q.size() != 0 || mem_q.size() != 0) && t < 500) begin
         cycle();
         t++;
      end
      check("drain_exp", 77'(exp_q.size()), 77'(0));
      check("drain_fwd", 77'(fwd_q.size()), 77'(0));
   endtask

   task automatic check_viol(input string tag);
      check({tag, "_intr"}, 77'(viol_intr), 77'(mv_set));
      check({tag, "_addr"}, 77'(viol_addr), 77'(mv_set ? mv_addr : 32'h0));
`ifdef PLAB2_DMEM_SEC_GUARD_VIOL_CNT_EN
      check({tag, "_cnt"}, 77'(viol_cnt), 77'(mv_n > 255 ? 255 : mv_n));
`endif
   endtask

   task automatic clear_viol();
      viol_clr = 1'b1;
      cycle();
      viol_clr = 1'b0;
      mv_set  = 1'b0;
      mv_addr = 32'h0;
      mv_n    = 0;
   endtask

   task automatic rand_req();
      logic [31:0] a;
      case ($urandom_range(4, 0))
         0: a = $urandom_range(32'h7FFF, 0);
         1: a = 32'h8000 + $urandom_range(32'h7FFF, 0);
         2: a = 32'h10000 + $urandom_range(32'hFFFF, 0);
         3: a = bnd[$urandom_range(3, 0)];
         default: a = $urandom;
      endcase
      req_domain = ($urandom_range(2, 0) == 0);
      in_req.msg = {3'($urandom_range(1, 0)), 8'($urandom), a,
                    2'($urandom), 32'($urandom)};
   endtask

   task automatic stall_step();
      if (!in_req.val || f_in) begin
         if (nsent < 6) begin
            req_domain = 1'b0;
            in_req.msg = {3'd0, 8'(8'h40 + nsent),
                          32'(32'h2000 + nsent * 4), 2'd0, 32'h0};
            in_req.val = 1'b1;
            nsent++;
         end else begin
            in_req.val = 1'b0;
         end
      end
      cycle();
   endtask

   initial begin
      int k;
      reset        = 1'b0;
      req_domain   = 1'b0;
      viol_clr     = 1'b0;
      in_req.val   = 1'b0;
      in_req.msg   = '0;
      out_req.rdy  = 1'b0;
      mem_resp.val = 1'b0;
      mem_resp.msg = '0;
      out_resp.rdy = 1'b0;
      #1;
      check("rst_in_rdy", 77'(in_req.rdy), 77'(0));
      check("rst_oreq_val", 77'(out_req.val), 77'(0));
      check("rst_oresp_val", 77'(out_resp.val), 77'(0));
      check("rst_mem_rdy", 77'(mem_resp.rdy), 77'(0));
      check("rst_intr", 77'(viol_intr), 77'(0));
      check("rst_addr", 77'(viol_addr), 77'(0));
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("post_rst_in_rdy", 77'(in_req.rdy), 77'(1));

      // Legal read: one-cycle latency, no combinational path
      out_req.rdy  = 1'b1;
      out_resp.rdy = 1'b1;
      k = n_issue;
      send(1'b0, 3'd0, 8'h11, 32'h1000);
      check("lat_nocomb", 77'(n_issue), 77'(k));
      check("lat_val", 77'(out_req.val), 77'(1));
      check("lat_msg", out_req.msg,
            {3'd0, 8'h11, 32'h1000, 2'd0, 32'h1234_1000});
      drain();
      check_viol("legal");

      // Violating write: never forwarded, synthesized reply
      send(1'b0, 3'd1, 8'h22, 32'h8004);
      check("viol_not_fwd", 77'(out_req.val), 77'(0));
      drain();
      check_viol("wr8004");

      // Domain and window boundaries
      send(1'b1, 3'd0, 8'h31, 32'h8004);
      send(1'b0, 3'd0, 8'h32, 32'h7FFC);
      send(1'b0, 3'd0, 8'h33, 32'h10000);
      send(1'b0, 3'd0, 8'h34, 32'hFFFF);
      drain();
      check_viol("bound");

      // Ordering with a slow memory
      mem_lo = 5;
      mem_hi = 5;
      send(1'b0, 3'd0, 8'hA1, 32'h0100);
      send(1'b0, 3'd0, 8'hB2, 32'h9000);
      send(1'b0, 3'd0, 8'hC3, 32'h0200);
      drain();

      // Outstanding limit under core back-pressure
      mem_lo = 1;
      mem_hi = 1;
      out_req.rdy  = 1'b1;
      out_resp.rdy = 1'b0;
      k = n_issue;
      nsent = 0;
      repeat (20) stall_step();
      check("stall_issued", 77'(n_issue - k), 77'(4));
      check("stall_in_rdy", 77'(in_req.rdy), 77'(0));
      out_resp.rdy = 1'b1;
      stall_step();
      out_resp.rdy = 1'b0;
      repeat (5) stall_step();
      check("stall_one_more", 77'(n_issue - k), 77'(5));
      drain();

      // Sticky flag, first address, clear
      mem_lo = 0;
      mem_hi = 2;
      clear_viol();
      send(1'b0, 3'd0, 8'h51, 32'h9000);
      drain();
      check_viol("v9000");
      send(1'b0, 3'd1, 8'h52, 32'hA000);
      drain();
      check_viol("vA000");
      clear_viol();
      check_viol("vclr");
      send(1'b0, 3'd0, 8'h53, 32'hB000);
      drain();
      check_viol("vB000");

      // Clear wins over a violation leaving the pipe that cycle
      clear_viol();
      send(1'b0, 3'd0, 8'h54, 32'hC000);
      viol_clr = 1'b1;
      cycle();
      viol_clr = 1'b0;
      mv_set  = 1'b0;
      mv_addr = 32'h0;
      mv_n    = 0;
      drain();
      check_viol("vprio");

      // Randomized traffic
      clear_viol();
      mem_lo = 0;
      mem_hi = 4;
      for (int i = 0; i < 400; i++) begin
         if (!in_req.val || f_in) begin
            in_req.val = ($urandom_range(3, 0) != 0);
            rand_req();
         end
         out_req.rdy  = ($urandom_range(3, 0) != 0);
         out_resp.rdy = ($urandom_range(3, 0) != 0);
         cycle();
      end
      drain();
      check_viol("rand");

      // Reset with three outstanding
      mem_lo = 1;
      mem_hi = 1;
      out_resp.rdy = 1'b0;
      send(1'b0, 3'd0, 8'h61, 32'h0300);
      send(1'b0, 3'd0, 8'h62, 32'h0304);
      send(1'b0, 3'd1, 8'h63, 32'h8100);
      repeat (3) cycle();
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_in_rdy", 77'(in_req.rdy), 77'(0));
      check("mid_rst_oreq", 77'(out_req.val), 77'(0));
      check("mid_rst_oresp", 77'(out_resp.val), 77'(0));
      check("mid_rst_mem_rdy", 77'(mem_resp.rdy), 77'(0));
      check("mid_rst_intr", 77'(viol_intr), 77'(0));
      check("mid_rst_addr", 77'(viol_addr), 77'(0));
      exp_q.delete();
      fwd_q.delete();
      mem_q.delete();
      mem_resp.val = 1'b0;
      mem_resp.msg = '0;
      mv_set  = 1'b0;
      mv_addr = 32'h0;
      mv_n    = 0;
      repeat (2) cycle();
      reset = 1'b1;
      #1;
      check("rel_oresp", 77'(out_resp.val), 77'(0));
      out_resp.rdy = 1'b1;
      send(1'b0, 3'd0, 8'h71, 32'h0400);
      drain();
      check_viol("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/plab2_mem_dmem_sec_guard.md
Name: plab2_mem_dmem_sec_guard

Overview:
- Sits directly downstream of the pipelined processor's data-memory port, between the core and the memory/cache system.
- Checks each data request against a secure address window, using the core's req_domain.
- Legal requests are forwarded through a one-entry pipe register. Violating requests are dropped and answered with a synthesized response in the correct order.
- Raises a sticky violation interrupt and latches the faulting address.

Parameters:
p_sec_base, 32'h0000_8000, first byte address of the secure window (inclusive)
p_sec_limit, 32'h0000_FFFF, last byte address of the secure window (inclusive)
p_max_outstanding, 4, depth of the in-order response tag FIFO (power of two, ≥2)

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
req_domain  input  1  domain of the current core request: 0 = normal, 1 = secure; sampled with in_req
in_req_msg  input  77  core memory request, VC_MEM_REQ_MSG_NBITS(8,32,32), fields {type[3],opaque[8],addr[32],len[2],data[32]}
in_req_val  input  1  request valid
in_req_rdy  output  1  request ready
out_req_msg  output  77  forwarded request, bit-identical to the accepted input
out_req_val  output  1  forwarded request valid
out_req_rdy  input  1  memory ready
mem_resp_msg  input  45  memory response, VC_MEM_RESP_MSG_NBITS(8,32), fields {type[3],opaque[8],len[2],data[32]}
mem_resp_val  input  1  memory response valid
mem_resp_rdy  output  1  memory response ready
out_resp_msg  output  45  response to core
out_resp_val  output  1  response valid
out_resp_rdy  input  1  core ready
viol_intr  output  1  sticky violation flag
viol_addr  output  32  address of the first violation since the last clear
viol_clr  input  1  one-cycle clear of viol_intr and viol_addr

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - pipe_val and the tag FIFO pointers/count;
  - viol_intr=0, viol_addr=0;
  - all val/rdy outputs = 0.
- Classification at accept:
  - viol = (req_domain==0) && (addr >= p_sec_base) && (addr <= p_sec_limit), unsigned 32-bit compares.
  - A secure-domain request is never a violation.
- Pipe register holds pipe_msg and pipe_viol.
  - in_req_rdy = !pipe_val || pipe_leave.
  - A new request is accepted on in_req_val && in_req_rdy and appears on out_req one cycle later (latency 1, no combinational in→out path).
- Tag FIFO holds {synth, type, opaque} per issued request, with count in 0..p_max_outstanding.
  - tag_ok = count < p_max_outstanding. No same-cycle pop-to-push bypass when full.
  - out_req_val = pipe_val && !pipe_viol && tag_ok; out_req_msg = pipe_msg.
  - pipe_leave = pipe_val && tag_ok && (pipe_viol || out_req_rdy).
  - On pipe_leave, push {pipe_viol, type, opaque}.
  - A violating request is never presented on out_req.
- Response path, driven by the head of the tag FIFO (count>0):
  - Head synth=0: pass-through. out_resp_val = mem_resp_val, mem_resp_rdy = out_resp_rdy, out_resp_msg = mem_resp_msg.
  - Head synth=1: mem_resp_rdy = 0 and out_resp_val = 1. out_resp_msg = {head.type, head.opaque, len=2'd0, data=32'h0}.
  - count==0: out_resp_val = 0 and mem_resp_rdy = 0. A memory response with no outstanding tag is a protocol error; it is held off.
  - Pop on out_resp_val && out_resp_rdy.
  - A simultaneous push and pop leaves count unchanged.
- Ordering: memory returns responses in order. Core responses come back in exact request-issue order, synthesized ones included.
- Violation flag:
  - On pipe_leave with pipe_viol: viol_intr←1; viol_addr←pipe addr only if viol_intr was 0.
  - viol_clr has priority over a same-cycle new violation: the flag clears, and the new violation is set on its next occurrence only.
- Reset mid-transaction discards the pipe entry and all outstanding tags. Late memory responses after reset are the system's responsibility.

Optional Feature:
- Macro PLAB2_DMEM_SEC_GUARD_VIOL_CNT_EN.
- Defined: adds output viol_cnt[7:0].
  - Saturating count of violations; +1 per violating pipe_leave, saturates at 8'hFF.
  - Cleared by reset and by viol_clr. On a same-cycle clear and violation, clear wins.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Normal-domain read addr 32'h1000, out_req_rdy=1 → out_req_val 1 cycle after accept, same msg. mem_resp data 32'hCAFE → out_resp data 32'hCAFE, viol_intr=0.
- Normal-domain write addr 32'h8004 → no out_req_val. Synthesized out_resp: type=write, opaque matching, data 0. viol_intr=1, viol_addr=32'h8004.
- Secure-domain read addr 32'h8004 → forwarded normally, no violation. Boundary addrs 32'h7FFC / 32'h10000 from normal domain → forwarded; 32'hFFFF → violation.
- Sequence legal A (mem delays 5 cycles), violating B, legal C → core receives responses strictly A, B, C. B's synthesized response is held until A completes.
- Memory stalls (out_resp_rdy=0 for 20 cycles) with 6 back-to-back legal requests → exactly 4 issued, in_req_rdy stays 0 with the pipe full. Releasing one response allows exactly one more issue.
- Two violations at 32'h9000 then 32'hA000, then viol_clr, then violation at 32'hB000 → viol_addr 32'h9000 until clear, then 0, then 32'hB000. With the macro defined, viol_cnt goes 1, 2, 0, 1.
- Assert reset with 3 outstanding → all val outputs 0 and count 0 immediately. A fresh request after release works normally.
